memcpy_ctrl: RTL

MEMCPY_CTRL -- requirements
Module: memcpy_ctrl

---
 rtl/memcpy_ctrl_if.sv | 40 ++++
 rtl/memcpy_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/memcpy_ctrl_if.sv
// Bus bundle for memcpy_ctrl: copy request/status, core load/store port and data-memory port.
// The slave modport is the controller's view; master is the requester/memory side.
interface memcpy_ctrl_if #(parameter int N_WIDTH = 7);
  logic               start;
  logic [31:0]        src_addr;
  logic [31:0]        dst_addr;
  logic [N_WIDTH-1:0] len;
  logic               busy;
  logic               done;

  logic               core_mem_read;
  logic               core_mem_write;
  logic [31:0]        core_addr;
  logic [31:0]        core_wdata;
  logic [1:0]         core_ls_type;
  logic               core_stall;

  logic               mem_read;
  logic               mem_write;
  logic [31:0]        mem_addr;
  logic [31:0]        mem_write_data;
  logic [1:0]         load_store_type;
  logic [31:0]        mem_read_data;

  modport slave (
    input  start, src_addr, dst_addr, len,
    input  core_mem_read, core_mem_write, core_addr, core_wdata, core_ls_type,
    input  mem_read_data,
    output busy, done, core_stall,
    output mem_read, mem_write, mem_addr, mem_write_data, load_store_type
  );

  modport master (
    output start, src_addr, dst_addr, len,
    output core_mem_read, core_mem_write, core_addr, core_wdata, core_ls_type,
    output mem_read_data,
    input  busy, done, core_stall,
    input  mem_read, mem_write, mem_addr, mem_write_data, load_store_type
  );
endinterface

// File: rtl/memcpy_ctrl.sv
// Memory-copy engine sharing the data-memory port with a core that always wins arbitration.
// Define MEMCPY_WORD_EN to allow 4-byte units when both pointers are aligned; otherwise bytes only.
module memcpy_ctrl #(
  parameter int N_WIDTH = 7
) (
  input logic          clk,
  input logic          rst,
  memcpy_ctrl_if.slave bus
);
  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

  state_t             r_state;
  logic [31:0]        r_src_ptr;
  logic [31:0]        r_dst_ptr;
  logic [N_WIDTH-1:0] r_remaining;
  logic [31:0]        r_buf;
  logic               r_busy;
  logic               r_done;

  logic               w_core_req;
  logic               w_word;
  logic [N_WIDTH-1:0] w_step;
  logic [31:0]        w_step32;
  logic [1:0]         w_unit_ls;
  logic               w_freeze;

  assign w_core_req = bus.core_mem_read | bus.core_mem_write;

`ifdef MEMCPY_WORD_EN
  assign w_word = (r_remaining >= N_WIDTH'(4)) &&
                  (r_src_ptr[1:0] == 2'b00) && (r_dst_ptr[1:0] == 2'b00);
`else
  assign w_word = 1'b0;
`endif

  assign w_step    = w_word ? N_WIDTH'(4) : N_WIDTH'(1);
  assign w_step32  = w_word ? 32'd4 : 32'd1;
  assign w_unit_ls = w_word ? LS_WORD : LS_BYTE;

  // Only the memory-using states stall behind the core; IDLE/DONE never touch the port.
  assign w_freeze = w_core_req && ((r_state == LOAD) || (r_state == STORE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_src_ptr   <= '0;
      r_dst_ptr   <= '0;
      r_remaining <= '0;
      r_buf       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (!w_freeze) begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_src_ptr   <= bus.src_addr;
            r_dst_ptr   <= bus.dst_addr;
            r_remaining <= bus.len;
            if (bus.len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= LOAD;
              r_busy  <= 1'b1;
            end
          end
        end
        LOAD: begin
          r_buf   <= bus.mem_read_data;
          r_state <= STORE;
        end
        STORE: begin
          r_src_ptr   <= r_src_ptr + w_step32;
          r_dst_ptr   <= r_dst_ptr + w_step32;
          r_remaining <= r_remaining - w_step;
          if (r_remaining == w_step) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= LOAD;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Reset masks the engine immediately so an aborted STORE never reaches memory.
  assign bus.busy       = r_busy & ~rst;
  assign bus.done       = r_done & ~rst;
  assign bus.core_stall = 1'b0;

  always_comb begin
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_addr        = '0;
    bus.mem_write_data  = '0;
    bus.load_store_type = LS_BYTE;
    if (w_core_req) begin
      bus.mem_read        = bus.core_mem_read;
      bus.mem_write       = bus.core_mem_write;
      bus.mem_addr        = bus.core_addr;
      bus.mem_write_data  = bus.core_wdata;
      bus.load_store_type = bus.core_ls_type;
    end else if (!rst && (r_state == LOAD)) begin
      bus.mem_read        = 1'b1;
      bus.mem_addr        = r_src_ptr;
      bus.load_store_type = w_unit_ls;
    end else if (!rst && (r_state == STORE)) begin
      bus.mem_write       = 1'b1;
      bus.mem_addr        = r_dst_ptr;
      bus.mem_write_data  = r_buf;
      bus.load_store_type = w_unit_ls;
    end
  end
endmodule
